me_search_ctrl: RTL and testbench

- Top-level sequencer for the 4-pixel-search motion estimation datapath.
- Drives the shared address generator (clear, search-window enable, template-block enable) and the memory write enables.
- Runs three phases: template-block load, search-window load, SAD compute. Emits per-candidate SAD accumulate and strobe controls, plus busy/done status.

---
 rtl/me_pkg.sv | 18 +
 rtl/me_search_ctrl.sv | 161 ++++++++++++++++
 tb/tb_me_search_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// Shared state encoding and default geometry for the motion estimation search controller.
package me_pkg;

  localparam int SW_AW_DEF = 10;
  localparam int TB_AW_DEF = 6;
  localparam int SW_WORDS  = 1 << SW_AW_DEF;
  localparam int TB_WORDS  = 1 << TB_AW_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_TB,
    S_LOAD_SW,
    S_PREP,
    S_COMPUTE,
    S_DONE
  } me_state_t;

endpackage

// File: rtl/me_search_ctrl.sv
// Phase sequencer for the 4-pixel-search motion estimation datapath: TB load, SW load, SAD compute.
// Optional cycle counter port perf_cycles is enabled by defining ME_SEARCH_CTRL_PERF_EN.
module me_search_ctrl
  import me_pkg::*;
#(
  parameter  int SW_AW = SW_AW_DEF,
  parameter  int TB_AW = TB_AW_DEF,
  localparam int CI_W  = SW_AW - TB_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            ld_valid,
  output logic            ld_ready,
  output logic            addr_clr,
  output logic            en_sw,
  output logic            en_tb,
  output logic            tb_we,
  output logic            sw_we,
  output logic            sad_clr,
  output logic            sad_acc,
  output logic            sad_last,
  output logic [CI_W-1:0] cand_idx,
  output logic            busy,
  output logic            done
`ifdef ME_SEARCH_CTRL_PERF_EN
  ,
  output logic [15:0]     perf_cycles
`endif
);

  localparam logic [SW_AW-1:0] CNT_TB_LAST = SW_AW'((1 << TB_AW) - 1);
  localparam logic [SW_AW-1:0] CNT_SW_LAST = '1;

  me_state_t        r_state;
  me_state_t        w_next_state;
  logic [SW_AW-1:0] r_cnt;
  logic [SW_AW-1:0] w_next_cnt;
  logic             w_start_ok;

  assign w_start_ok = (r_state == S_IDLE) && start && !abort;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    // NOTE: every output and next-state term gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    ld_ready     = 1'b0;
    addr_clr     = 1'b0;
    en_sw        = 1'b0;
    en_tb        = 1'b0;
    tb_we        = 1'b0;
    sw_we        = 1'b0;
    sad_clr      = 1'b0;
    sad_acc      = 1'b0;
    sad_last     = 1'b0;
    cand_idx     = '0;
    busy         = (r_state != S_IDLE);
    done         = 1'b0;

    if (rst) begin
      // Hold the address generator at zero while the controller is in reset.
      addr_clr = 1'b1;
      busy     = 1'b0;
    end else if (abort && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
      w_next_cnt   = '0;
      addr_clr     = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            w_next_state = S_LOAD_TB;
            w_next_cnt   = '0;
            addr_clr     = 1'b1;
          end
        end
        S_LOAD_TB: begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            tb_we = 1'b1;
            en_tb = 1'b1;
            if (r_cnt == CNT_TB_LAST) begin
              w_next_state = S_LOAD_SW;
              w_next_cnt   = '0;
            end else begin
              w_next_cnt = r_cnt + 1'b1;
            end
          end
        end
        S_LOAD_SW: begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            sw_we = 1'b1;
            en_sw = 1'b1;
            if (r_cnt == CNT_SW_LAST) begin
              w_next_state = S_PREP;
              w_next_cnt   = '0;
            end else begin
              w_next_cnt = r_cnt + 1'b1;
            end
          end
        end
        S_PREP: begin
          // Rewind both address streams before compute; clr never overlaps an increment.
          addr_clr     = 1'b1;
          w_next_state = S_COMPUTE;
          w_next_cnt   = '0;
        end
        S_COMPUTE: begin
          en_sw    = 1'b1;
          en_tb    = 1'b1;
          sad_acc  = 1'b1;
          sad_clr  = (r_cnt[TB_AW-1:0] == '0);
          sad_last = (r_cnt[TB_AW-1:0] == '1);
          cand_idx = r_cnt[SW_AW-1:TB_AW];
          if (r_cnt == CNT_SW_LAST) begin
            w_next_state = S_DONE;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          done         = 1'b1;
          addr_clr     = 1'b1;
          w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

`ifdef ME_SEARCH_CTRL_PERF_EN
  logic [15:0] r_perf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= '0;
    end else if (w_start_ok) begin
      r_perf <= '0;
    end else if (busy && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_me_search_ctrl.sv
// Self-checking bench for me_search_ctrl: randomized load backpressure against a timeline model.
// Build with ME_SEARCH_CTRL_PERF_EN defined to also check perf_cycles.
module tb_me_search_ctrl;
  import me_pkg::*;

  localparam int SW_AW      = SW_AW_DEF;
  localparam int TB_AW      = TB_AW_DEF;
  localparam int CI_W       = SW_AW - TB_AW;
  localparam int NCAND      = 1 << CI_W;
  localparam int LOAD_WORDS = TB_WORDS + SW_WORDS;
  localparam int NOM_DONE   = 1 + LOAD_WORDS + 1 + SW_WORDS + 1;

  typedef struct packed {
    logic            ld_ready;
    logic            addr_clr;
    logic            en_sw;
    logic            en_tb;
    logic            tb_we;
    logic            sw_we;
    logic            sad_clr;
    logic            sad_acc;
    logic            sad_last;
    logic            busy;
    logic            done;
    logic [CI_W-1:0] cand_idx;
  } obs_t;

  logic clk = 1'b0;
  logic rst, start, abort, ld_valid;
  logic ld_ready, addr_clr, en_sw, en_tb, tb_we, sw_we;
  logic sad_clr, sad_acc, sad_last, busy, done;
  logic [CI_W-1:0] cand_idx;
`ifdef ME_SEARCH_CTRL_PERF_EN
  logic [15:0] perf_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  me_search_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .addr_clr (addr_clr),
    .en_sw    (en_sw),
    .en_tb    (en_tb),
    .tb_we    (tb_we),
    .sw_we    (sw_we),
    .sad_clr  (sad_clr),
    .sad_acc  (sad_acc),
    .sad_last (sad_last),
    .cand_idx (cand_idx),
    .busy     (busy),
    .done     (done)
`ifdef ME_SEARCH_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  // Stand-in for the datapath address generator: clr has priority, each stream wraps by width.
  logic [SW_AW-1:0] a_sw;
  logic [TB_AW-1:0] a_tb;
  always @(posedge clk) begin
    if (addr_clr) begin
      a_sw <= '0;
      a_tb <= '0;
    end else begin
      if (en_sw) a_sw <= a_sw + 1'b1;
      if (en_tb) a_tb <= a_tb + 1'b1;
    end
  end

  // Load stream: vq[j] is ld_valid in load slot j, pb[j] the beats accepted before that slot.
  bit vq[$];
  int pb[$];

  int   cyc_err, bad_cyc, n_tb_we, n_sw_we, n_sad_clr, n_sad_last, n_done, done_cyc;
  int   n_stall_en, run_len;
  bit   addr_ok;
  obs_t bad_act, bad_exp;

  function automatic obs_t sample();
    return {ld_ready, addr_clr, en_sw, en_tb, tb_we, sw_we, sad_clr, sad_acc, sad_last,
            busy, done, cand_idx};
  endfunction

  // Expected outputs in cycle c (start cycle = 1) from the phase lengths alone.
  function automatic obs_t expect_at(input int c, input int L, input int A, output bit skip_rdy);
    obs_t e;
    int   j, k;
    e        = '0;
    skip_rdy = 1'b0;
    j        = c - 2;
    k        = c - L - 3;
    if (A > 0 && c > A) return e;
    if (A > 0 && c == A) begin
      e.addr_clr = 1'b1;
      e.busy     = 1'b1;
      skip_rdy   = 1'b1;
    end else if (c == 1) begin
      e.addr_clr = 1'b1;
    end else if (j >= 0 && j < L) begin
      e.ld_ready = 1'b1;
      e.busy     = 1'b1;
      if (pb[j] < TB_WORDS) begin
        e.tb_we = vq[j];
        e.en_tb = vq[j];
      end else begin
        e.sw_we = vq[j];
        e.en_sw = vq[j];
      end
    end else if (c == L + 2) begin
      e.addr_clr = 1'b1;
      e.busy     = 1'b1;
    end else if (k >= 0 && k < SW_WORDS) begin
      e.en_sw    = 1'b1;
      e.en_tb    = 1'b1;
      e.sad_acc  = 1'b1;
      e.busy     = 1'b1;
      e.sad_clr  = (k % TB_WORDS) == 0;
      e.sad_last = (k % TB_WORDS) == TB_WORDS - 1;
      e.cand_idx = CI_W'(k / TB_WORDS);
    end else if (k == SW_WORDS) begin
      e.done     = 1'b1;
      e.addr_clr = 1'b1;
      e.busy     = 1'b1;
    end
    return e;
  endfunction

  // vmode 0: ld_valid always 1; 1: toggling 1,0; 2: random, about 3 in 4 high.
  task automatic build_timeline(input int vmode);
    int ones;
    bit v;
    vq.delete();
    pb.delete();
    ones = 0;
    while (ones < LOAD_WORDS) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (vq.size() % 2) == 0;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      pb.push_back(ones);
      vq.push_back(v);
      ones += int'(v);
    end
    run_len = vq.size();
  endtask

  // abort_sw >= 0: abort once that many SW beats are in; start_k >= 0: stray start in compute cycle k.
  task automatic run_search(input int abort_sw, input int start_k);
    int   L, A, last;
    obs_t o, e;
    bit   skip;
    L = run_len;
    A = 0;
    if (abort_sw >= 0) begin
      for (int j = 0; j < L; j++) begin
        if (pb[j] == TB_WORDS + abort_sw) begin
          A = j + 2;
          break;
        end
      end
    end
    last = ((A > 0) ? A : (L + 3 + SW_WORDS)) + 16;
    cyc_err = 0; bad_cyc = 0; n_tb_we = 0; n_sw_we = 0; n_sad_clr = 0; n_sad_last = 0;
    n_done = 0; done_cyc = 0; n_stall_en = 0; addr_ok = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      start    = (c == 1) || (start_k >= 0 && c == L + 3 + start_k);
      abort    = (A > 0 && c == A);
      ld_valid = (c >= 2 && c - 2 < L && !(A > 0 && c > A)) ? vq[c-2] : 1'b0;
      @(negedge clk);
      o = sample();
      e = expect_at(c, L, A, skip);
      if (skip) o.ld_ready = e.ld_ready;
      if (o !== e) begin
        cyc_err++;
        if (cyc_err == 1) begin
          bad_cyc = c;
          bad_act = o;
          bad_exp = e;
        end
      end
      n_tb_we    += int'(tb_we);
      n_sw_we    += int'(sw_we);
      n_sad_clr  += int'(sad_clr);
      n_sad_last += int'(sad_last);
      if (c >= 2 && c - 2 < L && !ld_valid && (tb_we || sw_we || en_tb || en_sw)) n_stall_en++;
      if (done === 1'b1) begin
        n_done++;
        done_cyc = c;
        addr_ok  = (a_sw === '0) && (a_tb === '0);
      end
    end
    start    = 1'b0;
    abort    = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ld_valid = 1'b0;
    e = '0;
    e.addr_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_cycle%0d: got %h expected %h", i, o, e);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected 0", o);
    end
  endtask

  task automatic test_nominal();
    build_timeline(0);
    run_search(-1, -1);
    checks++; if (cyc_err != 0) begin errors++;
      $display("FAIL nominal_cycles: %0d bad, first c=%0d got %h expected %h", cyc_err, bad_cyc, bad_act, bad_exp); end
    checks++; if (n_tb_we != TB_WORDS) begin errors++;
      $display("FAIL nominal_tb_we: got %0d expected %0d", n_tb_we, TB_WORDS); end
    checks++; if (n_sw_we != SW_WORDS) begin errors++;
      $display("FAIL nominal_sw_we: got %0d expected %0d", n_sw_we, SW_WORDS); end
    checks++; if (n_sad_clr != NCAND || n_sad_last != NCAND) begin errors++;
      $display("FAIL nominal_sad_pulses: got clr=%0d last=%0d expected %0d", n_sad_clr, n_sad_last, NCAND); end
    checks++; if (n_done != 1 || done_cyc != NOM_DONE) begin errors++;
      $display("FAIL nominal_done: got %0d pulses at cycle %0d expected 1 at %0d", n_done, done_cyc, NOM_DONE); end
    checks++; if (!addr_ok) begin errors++;
      $display("FAIL nominal_addr_at_done: got sw=%0d tb=%0d expected 0 0", a_sw, a_tb); end
`ifdef ME_SEARCH_CTRL_PERF_EN
    checks++; if (perf_cycles !== 16'(NOM_DONE - 1)) begin errors++;
      $display("FAIL nominal_perf: got %0d expected %0d", perf_cycles, NOM_DONE - 1); end
`endif
  endtask

  task automatic test_backpressure(input int vmode);
    int stalls;
    build_timeline(vmode);
    stalls = run_len - LOAD_WORDS;
    run_search(-1, -1);
    checks++; if (cyc_err != 0) begin errors++;
      $display("FAIL bp%0d_cycles: %0d bad, first c=%0d got %h expected %h", vmode, cyc_err, bad_cyc, bad_act, bad_exp); end
    checks++; if (n_tb_we != TB_WORDS || n_sw_we != SW_WORDS) begin errors++;
      $display("FAIL bp%0d_writes: got tb=%0d sw=%0d expected %0d %0d", vmode, n_tb_we, n_sw_we, TB_WORDS, SW_WORDS); end
    checks++; if (n_stall_en != 0) begin errors++;
      $display("FAIL bp%0d_stall_enables: got %0d expected 0", vmode, n_stall_en); end
    checks++; if (n_done != 1 || done_cyc != NOM_DONE + stalls) begin errors++;
      $display("FAIL bp%0d_done: got %0d pulses at cycle %0d expected 1 at %0d", vmode, n_done, done_cyc, NOM_DONE + stalls); end
    checks++; if (!addr_ok) begin errors++;
      $display("FAIL bp%0d_addr_at_done: got sw=%0d tb=%0d expected 0 0", vmode, a_sw, a_tb); end
`ifdef ME_SEARCH_CTRL_PERF_EN
    checks++; if (perf_cycles !== 16'(NOM_DONE - 1 + stalls)) begin errors++;
      $display("FAIL bp%0d_perf: got %0d expected %0d", vmode, perf_cycles, NOM_DONE - 1 + stalls); end
`endif
  endtask

  task automatic test_abort();
    build_timeline(2);
    run_search(500, -1);
    checks++; if (cyc_err != 0) begin errors++;
      $display("FAIL abort_cycles: %0d bad, first c=%0d got %h expected %h", cyc_err, bad_cyc, bad_act, bad_exp); end
    checks++; if (n_tb_we != TB_WORDS || n_sw_we != 500) begin errors++;
      $display("FAIL abort_writes: got tb=%0d sw=%0d expected %0d 500", n_tb_we, n_sw_we, TB_WORDS); end
    checks++; if (n_done != 0) begin errors++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", n_done); end
    build_timeline(0);
    run_search(-1, -1);
    checks++; if (cyc_err != 0) begin errors++;
      $display("FAIL abort_rerun_cycles: %0d bad, first c=%0d got %h expected %h", cyc_err, bad_cyc, bad_act, bad_exp); end
    checks++; if (n_done != 1 || done_cyc != NOM_DONE || n_sw_we != SW_WORDS) begin errors++;
      $display("FAIL abort_rerun_done: got %0d pulses at %0d sw=%0d expected 1 at %0d sw=%0d",
               n_done, done_cyc, n_sw_we, NOM_DONE, SW_WORDS); end
  endtask

  task automatic test_start_in_compute();
    build_timeline(2);
    run_search(-1, int'($urandom_range(0, SW_WORDS - 1)));
    checks++; if (cyc_err != 0) begin errors++;
      $display("FAIL start_in_compute_cycles: %0d bad, first c=%0d got %h expected %h", cyc_err, bad_cyc, bad_act, bad_exp); end
    checks++; if (n_done != 1) begin errors++;
      $display("FAIL start_in_compute_done: got %0d pulses expected 1", n_done); end
  endtask

  task automatic test_abort_start_idle();
    obs_t o;
    int   n_bad;
    @(posedge clk);
    #1 start = 1'b1; abort = 1'b1;
    @(negedge clk);
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL idle_abort_start: got %h expected 0", o);
    end
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    n_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || ld_ready !== 1'b0) n_bad++;
    end
    checks++;
    if (n_bad != 0) begin
      errors++;
      $display("FAIL idle_abort_start_after: got %0d busy cycles expected 0", n_bad);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure(1);
    test_backpressure(2);
    test_abort();
    test_start_in_compute();
    test_abort_start_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
